// File: rtl/bcd_alu_pkg.sv
// Shared constants, state encoding and operand validation for the digit-serial BCD add/subtract sequencer.
package bcd_alu_pkg;
    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 4;
    localparam int MAG_W      = DIGIT_W * NUM_DIGITS;
    localparam int W          = DIGIT_W * (NUM_DIGITS + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIGIT_W-1:0] SIGN_POS = 4'hF;
    localparam logic [DIGIT_W-1:0] SIGN_NEG = 4'hE;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ORDER  = 3'd1;
    localparam logic [2:0] S_DIGIT  = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_t;

    // A legal operand has a recognised sign nibble and only decimal magnitude digits.
    function automatic logic operand_ok(input logic [W-1:0] op);
        logic ok;
        ok = (op[W-1 -: DIGIT_W] == SIGN_POS) || (op[W-1 -: DIGIT_W] == SIGN_NEG);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (op[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction
endpackage

// File: rtl/bcd_alu_sequencer_if.sv
// Request/result bundle between the operand-entry front end (master) and the BCD sequencer (slave).
interface bcd_alu_sequencer_if;
    import bcd_alu_pkg::*;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         err;

    modport master (output start, op_a, op_b, input busy, done, result, overflow, err);
    modport slave  (input start, op_a, op_b, output busy, done, result, overflow, err);
endinterface

// File: rtl/bcd_digit_unit.sv
// Single-digit BCD adder/subtractor with decimal correction; purely combinational, zero latency.
module bcd_digit_unit
    import bcd_alu_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic [DIGIT_W-1:0] d,
    output logic               cout
);
    logic [DIGIT_W:0] sum;
    logic [DIGIT_W:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, cin};
        if (sub) begin
            // Top bit of the 5-bit difference is the borrow; adding 10 mod 16 restores the decimal digit.
            cout = diff[DIGIT_W];
            d    = diff[DIGIT_W] ? diff[DIGIT_W-1:0] + 4'd10 : diff[DIGIT_W-1:0];
        end else begin
            cout = (sum > 5'd9);
            d    = cout ? sum[DIGIT_W-1:0] + 4'd6 : sum[DIGIT_W-1:0];
        end
    end
endmodule

// File: rtl/bcd_alu_sequencer.sv
// Signed sign-magnitude BCD add/subtract, one digit per cycle through a shared digit unit.
// Done pulses NUM_DIGITS+2 edges after the start edge (same edge for bad operands); start is ignored unless idle.
module bcd_alu_sequencer
    import bcd_alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    bcd_alu_sequencer_if.slave io
);
    logic [2:0]         state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [MAG_W-1:0]   x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [DIGIT_W-1:0] sign_q, sign_d;
    mode_t              mode_q, mode_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       result_q, result_d;
    logic               ovf_q, ovf_d, err_q, err_d;

    logic [DIGIT_W-1:0] dig_x, dig_y, dig_r;
    logic               dig_cout;
    logic               a_gt, mag_eq;

    assign a_gt   = a_q[MAG_W-1:0] > b_q[MAG_W-1:0];
    assign mag_eq = a_q[MAG_W-1:0] == b_q[MAG_W-1:0];

    always_comb begin
        dig_x = '0;
        dig_y = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_x = x_q[i*DIGIT_W +: DIGIT_W];
                dig_y = y_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    bcd_digit_unit u_digit (
        .a    (dig_x),
        .b    (dig_y),
        .cin  (carry_q),
        .sub  (mode_q == MODE_SUB),
        .d    (dig_r),
        .cout (dig_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    a_d = io.op_a;
                    b_d = io.op_b;
                    if (!operand_ok(io.op_a) || !operand_ok(io.op_b)) begin
                        result_d = {SIGN_POS, {MAG_W{1'b0}}};
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_ORDER;
                    end
                end
            end
            S_ORDER: begin
                // Result sign is fixed here so FINISH only has to assemble the word.
                if (a_q[W-1 -: DIGIT_W] == b_q[W-1 -: DIGIT_W]) begin
                    mode_d = MODE_ADD;
                    x_d    = a_q[MAG_W-1:0];
                    y_d    = b_q[MAG_W-1:0];
                    sign_d = a_q[W-1 -: DIGIT_W];
                end else if (a_gt) begin
                    mode_d = MODE_SUB;
                    x_d    = a_q[MAG_W-1:0];
                    y_d    = b_q[MAG_W-1:0];
                    sign_d = a_q[W-1 -: DIGIT_W];
                end else begin
                    mode_d = MODE_SUB;
                    x_d    = b_q[MAG_W-1:0];
                    y_d    = a_q[MAG_W-1:0];
                    sign_d = mag_eq ? SIGN_POS : b_q[W-1 -: DIGIT_W];
                end
                carry_d = 1'b0;
                idx_d   = '0;
                acc_d   = '0;
                state_d = S_DIGIT;
            end
            S_DIGIT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) acc_d[i*DIGIT_W +: DIGIT_W] = dig_r;
                end
                carry_d = dig_cout;
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FINISH: begin
                result_d = {sign_q, acc_q};
                ovf_d    = (mode_q == MODE_ADD) && carry_q;
                err_d    = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            sign_q   <= SIGN_POS;
            mode_q   <= MODE_ADD;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= {SIGN_POS, {MAG_W{1'b0}}};
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign io.busy     = (state_q == S_ORDER) || (state_q == S_DIGIT) || (state_q == S_FINISH);
    assign io.done     = (state_q == S_DONE);
    assign io.result   = result_q;
    assign io.overflow = ovf_q;
    assign io.err      = err_q;
endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Table-driven bench with a result scoreboard for the BCD add/subtract sequencer.
module tb_bcd_alu_sequencer;
    logic clk;
    logic reset;

    bcd_alu_sequencer_if io ();

    bcd_alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
        logic        err;
    } vec_t;

    localparam int N_VEC = 14;
    vec_t vecs [N_VEC];
    vec_t sb [$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (io.done === 1'b1) begin
            vec_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with no request outstanding, result %0h", io.result);
            end else begin
                e = sb.pop_front();
                check("result",   32'(io.result),   32'(e.res));
                check("overflow", 32'(io.overflow), 32'(e.ovf));
                check("err",      32'(io.err),      32'(e.err));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int cyc;
        int busy_cyc;
        @(negedge clk);
        io.start = 1'b1;
        io.op_a  = v.a;
        io.op_b  = v.b;
        sb.push_back(v);
        @(negedge clk);
        io.start = 1'b0;
        io.op_a  = 16'($urandom);
        io.op_b  = 16'($urandom);
        cyc      = 1;
        busy_cyc = 0;
        while (io.done !== 1'b1 && cyc < 20) begin
            if (io.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        if (io.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles for a=%0h b=%0h", cyc, v.a, v.b);
            void'(sb.pop_back());
        end else begin
            check("latency",      32'(cyc),      v.err ? 32'd1 : 32'd6);
            check("busy_cycles",  32'(busy_cyc), v.err ? 32'd0 : 32'd5);
            check("busy_at_done", 32'(io.busy),  32'd0);
        end
        @(negedge clk);
        check("done_pulse_width", 32'(io.done), 32'd0);
    endtask

    initial begin
        int dc;
        vecs[0]  = '{16'hF123, 16'hF456, 16'hF579, 1'b0, 1'b0};
        vecs[1]  = '{16'hF999, 16'hF001, 16'hF000, 1'b1, 1'b0};
        vecs[2]  = '{16'hF250, 16'hE300, 16'hE050, 1'b0, 1'b0};
        vecs[3]  = '{16'hE045, 16'hE055, 16'hE100, 1'b0, 1'b0};
        vecs[4]  = '{16'hF250, 16'hE250, 16'hF000, 1'b0, 1'b0};
        vecs[5]  = '{16'hF1A3, 16'hF001, 16'hF000, 1'b0, 1'b1};
        vecs[6]  = '{16'h0123, 16'hF001, 16'hF000, 1'b0, 1'b1};
        vecs[7]  = '{16'hE500, 16'hF123, 16'hE377, 1'b0, 1'b0};
        vecs[8]  = '{16'hF007, 16'hE009, 16'hE002, 1'b0, 1'b0};
        vecs[9]  = '{16'hF010, 16'hE001, 16'hF009, 1'b0, 1'b0};
        vecs[10] = '{16'hE000, 16'hF000, 16'hF000, 1'b0, 1'b0};
        vecs[11] = '{16'hF123, 16'hD123, 16'hF000, 1'b0, 1'b1};
        vecs[12] = '{16'hF123, 16'hFA00, 16'hF000, 1'b0, 1'b1};
        vecs[13] = '{16'hE999, 16'hE999, 16'hE998, 1'b1, 1'b0};

        reset    = 1'b1;
        io.start = 1'b0;
        io.op_a  = '0;
        io.op_b  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",     32'(io.busy),     32'd0);
        check("reset_done",     32'(io.done),     32'd0);
        check("reset_result",   32'(io.result),   32'hF000);
        check("reset_overflow", 32'(io.overflow), 32'd0);
        check("reset_err",      32'(io.err),      32'd0);
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) run_op(vecs[i]);

        // Starts at cycle 2 and on the done cycle must both be ignored.
        @(negedge clk);
        io.start = 1'b1;
        io.op_a  = 16'hF123;
        io.op_b  = 16'hF456;
        sb.push_back(vecs[0]);
        dc = done_cnt;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            io.start = (c == 2) || (c == 6);
            io.op_a  = (c == 2) ? 16'hF111 : 16'hF222;
            io.op_b  = (c == 2) ? 16'hF111 : 16'hF222;
            if (c == 6) check("ignored_start_done_cycle", 32'(io.done), 32'd1);
        end
        check("ignored_start_done_count", 32'(done_cnt - dc), 32'd1);
        check("result_held",              32'(io.result),     32'hF579);
        io.start = 1'b0;

        // Abort in DIGIT after an overflowing add so the reset values are distinguishable.
        run_op(vecs[13]);
        @(negedge clk);
        io.start = 1'b1;
        io.op_a  = 16'hF123;
        io.op_b  = 16'hF456;
        @(negedge clk);
        io.start = 1'b0;
        repeat (2) @(negedge clk);
        dc = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("abort_busy",     32'(io.busy),     32'd0);
        check("abort_done",     32'(io.done),     32'd0);
        check("abort_result",   32'(io.result),   32'hF000);
        check("abort_overflow", 32'(io.overflow), 32'd0);
        check("abort_err",      32'(io.err),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);

        run_op(vecs[2]);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
